bicubic_kernel_engine: RTL and testbench
========================================

# bicubic_kernel_engine

Parametrised 4×4 bicubic convolution engine for the AXI4-Stream upscaler. It takes a 16-tap pixel window per channel and one shared 16-tap signed weight set, and produces one rounded, clamped output sample per channel. It adds full valid/ready backpressure, with a credit-managed output FIFO so no accepted window is ever dropped, and carries sideband user bits aligned with the data. It sits between the window/line-buffer stage and the AXI4-Stream output formatter.

## Interface
- CHANNELS, 3: number of colour channels processed in parallel.
- PIX_W, 8: unsigned pixel width, input and output.
- COEF_W, 16: signed weight width, two's complement.
- COEF_FRAC, 14: fractional bits of the weights; 1.0 = 16384 at default.
- USER_W, 2: sideband width (e.g. tlast/tuser), passed through unchanged.
- FIFO_DEPTH, 8: output FIFO entries; must be ≥ 5.
- i_clk  in  1  sole clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  input window valid.
- o_ready  out  1  engine can accept a window this cycle.
- i_pixel  in  CHANNELS*16*PIX_W  channel c, tap k at [(c*16+k)*PIX_W +: PIX_W]; k = row*4+col.
- i_weight  in  16*COEF_W  tap k at [k*COEF_W +: COEF_W]; shared by all channels.
- i_user  in  USER_W  sideband bits for this window.
- o_valid  out  1  output sample valid.
- i_ready  in  1  downstream accepts the output.
- o_pixel  out  CHANNELS*PIX_W  channel c at [c*PIX_W +: PIX_W].
- o_user  out  USER_W  sideband bits of the window that produced o_pixel.

## Operation
- Accept: i_valid & o_ready at a rising edge. Pop: o_valid & i_ready at a rising edge.
- Arithmetic per channel:
  - Each pixel is zero-extended and multiplied by its signed weight. Products keep full precision (PIX_W+COEF_W+1 bits).
  - The 16 products are summed in a 2-level registered adder tree, 4 bits of growth, no intermediate truncation.
  - Result = (sum + rounding) >>> COEF_FRAC (arithmetic shift), then clamped to [0, 2^PIX_W−1].
- Pipeline: S1 registers the inputs; S2 registers the products; S3 registers four 4-tap partial sums; S4 forms the final sum, rounds, clamps and writes the FIFO.
- The pipeline never stalls. Backpressure is handled entirely by credits.
- Credit counter occ (0..FIFO_DEPTH) counts in-flight plus stored windows:
  - occ increments on accept and decrements on pop.
  - Accept and pop in the same cycle leave occ unchanged.
- o_ready = (occ < FIFO_DEPTH), decoded from registers only. There is no combinational path from i_ready or i_valid to o_ready.
- The output FIFO is first-word-fall-through. o_pixel and o_user hold stable while o_valid & ~i_ready.
- Output order equals acceptance order. o_user is bit-exact with the i_user of the same window.

## Timing
- Latency: a window accepted at edge t gives o_valid with its result after edge t+4, provided the FIFO is empty and no older output is pending.
- Throughput: 1 window per cycle, sustained, while i_ready stays high.
- Full: with i_ready held low, exactly FIFO_DEPTH windows are accepted, then o_ready drops. o_ready rises again in the cycle after the first pop.
- Empty: o_valid = 0 and o_pixel holds its last value. i_ready is ignored.
- Reset (async assert, any time including mid-stream):
  - Effective immediately: o_valid = 0, o_ready = 0, o_pixel = 0, o_user = 0, occ = 0, FIFO empty, all stage valids cleared.
  - All in-flight windows are discarded.
  - o_ready = 1 from the first edge after deassertion.
- Weights and pixels are sampled only on accept. Changes on i_weight between accepts have no effect.

## Configuration
- BICUBIC_ROUND_EN defined: rounding = 2^(COEF_FRAC−1), i.e. round half up (toward +∞) before the shift.
- BICUBIC_ROUND_EN undefined: rounding = 0, i.e. floor via arithmetic shift. Latency and the interface are unchanged.

## Test plan
- Identity: weight tap5 = 16384, all other taps 0; channel pixels tap5 = 200/17/255; single accept at edge t -> o_valid after edge t+4 with o_pixel = 200/17/255, o_user echoed.
- Clamp: all weights 16384, all pixels 255 -> 255. All weights −4096, all pixels 100 -> 0.
- Rounding: tap0 weight 8192, pixel 3, others 0 -> 2 with BICUBIC_ROUND_EN, 1 without. Pixel 5, weight −2458 -> 0 in both builds.
- Backpressure: i_valid continuous, i_ready low 20 cycles -> exactly 8 accepts, o_ready low until the first pop. Then i_ready high -> 8 results in order (ramp data 0..7 via tap5 identity), no loss or duplication.
- Streaming: 100 random windows with i_ready toggling randomly -> output matches the reference model bit-exact in order. Accept and pop in the same cycle leave occ constant.
- Reset mid-stream: assert i_reset with 6 windows in flight -> o_valid drops immediately, o_ready = 1 one edge after release, no stale outputs afterward.

Source files
------------

// File: rtl/bicubic_kernel_engine.sv
// bicubic_kernel_engine
// 4x4 bicubic convolution over CHANNELS colour planes with one shared signed
// weight set. A fixed four-stage pipeline feeds a first-word-fall-through
// output FIFO. The FIFO never overflows because input acceptance is limited by
// a credit counter that counts windows both in flight and stored.
// Build option: define BICUBIC_ROUND_EN to round half up before the final
// shift. Without it, the shift floors.
module bicubic_kernel_engine #(
    parameter int CHANNELS   = 3,
    parameter int PIX_W      = 8,
    parameter int COEF_W     = 16,
    parameter int COEF_FRAC  = 14,
    parameter int USER_W     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [CHANNELS*16*PIX_W-1:0] i_pixel,
    input  logic [16*COEF_W-1:0]         i_weight,
    input  logic [USER_W-1:0]            i_user,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [CHANNELS*PIX_W-1:0]    o_pixel,
    output logic [USER_W-1:0]            o_user
);
    localparam int TAPS   = 16;
    localparam int PROD_W = PIX_W + COEF_W + 1;
    localparam int PART_W = PROD_W + 2;
    localparam int SUM_W  = PROD_W + 4;
    localparam int RES_W  = SUM_W + 1;          // headroom for the rounding constant
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W  = CHANNELS * PIX_W;

`ifdef BICUBIC_ROUND_EN
    localparam logic signed [RES_W-1:0] ROUND_K = RES_W'(64'sd1 <<< (COEF_FRAC - 1));
`else
    localparam logic signed [RES_W-1:0] ROUND_K = '0;
`endif
    localparam logic signed [RES_W-1:0] PIX_MAX = RES_W'((64'sd1 <<< PIX_W) - 64'sd1);

    logic             accept, pop, load, ready_en;
    logic [CNT_W-1:0] occ, mem_cnt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             s1_valid, s2_valid, s3_valid;

    logic        [PIX_W-1:0]  s1_pix  [CHANNELS][TAPS];
    logic signed [COEF_W-1:0] s1_wt   [TAPS];
    logic signed [PROD_W-1:0] s2_prod [CHANNELS][TAPS];
    logic signed [PART_W-1:0] s3_part [CHANNELS][4];
    logic [USER_W-1:0]        s1_user, s2_user, s3_user;
    logic [OUT_W-1:0]         s4_pix;

    logic [OUT_W-1:0]  mem_pix  [FIFO_DEPTH];
    logic [USER_W-1:0] mem_user [FIFO_DEPTH];

    // o_ready depends only on registers. It never depends on i_ready or i_valid.
    assign accept  = i_valid & o_ready;
    assign pop     = o_valid & i_ready;
    assign o_ready = ready_en & (occ < CNT_W'(FIFO_DEPTH));
    assign load    = (mem_cnt != '0) && (!o_valid || i_ready);

    // Final sum, rounding, arithmetic shift and clamp for one channel.
    function automatic logic [PIX_W-1:0] finish_sample(
        input logic signed [PART_W-1:0] p0, p1, p2, p3
    );
        logic signed [RES_W-1:0] sum, shifted;
        sum     = RES_W'(p0) + RES_W'(p1) + RES_W'(p2) + RES_W'(p3) + ROUND_K;
        shifted = sum >>> COEF_FRAC;
        if (shifted[RES_W-1])       return '0;
        else if (shifted > PIX_MAX) return '1;
        else                        return shifted[PIX_W-1:0];
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit counter. ready_en keeps o_ready low until the first edge after reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            occ      <= '0;
            ready_en <= 1'b0;
        end else begin
            // NOTE: state is updated with <= so every flop samples pre-edge values.
            ready_en <= 1'b1;
            if (accept && !pop)      occ <= occ + CNT_W'(1);
            else if (pop && !accept) occ <= occ - CNT_W'(1);
        end
    end

    // Stage valid chain. This is the only pipeline state that reset clears.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    // S1: capture the window only on accept.
    // NOTE: datapath registers and FIFO storage have no reset. The valids and counters qualify their contents.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < TAPS; k++)
                    s1_pix[c][k] <= i_pixel[(c*TAPS+k)*PIX_W +: PIX_W];
            for (int k = 0; k < TAPS; k++)
                s1_wt[k] <= i_weight[k*COEF_W +: COEF_W];
            s1_user <= i_user;
        end
    end

    // S2: full-precision products of each zero-extended pixel and its signed weight.
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < TAPS; k++)
                s2_prod[c][k] <= PROD_W'($signed({1'b0, s1_pix[c][k]})) * PROD_W'(s1_wt[k]);
        s2_user <= s1_user;
    end

    // S3: four 4-tap partial sums per channel, one for each kernel row.
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < CHANNELS; c++)
            for (int g = 0; g < 4; g++)
                s3_part[c][g] <= PART_W'(s2_prod[c][4*g])   + PART_W'(s2_prod[c][4*g+1])
                               + PART_W'(s2_prod[c][4*g+2]) + PART_W'(s2_prod[c][4*g+3]);
        s3_user <= s2_user;
    end

    // S4: form the final sum, then round and clamp every channel.
    always_comb begin
        // NOTE: assigning a default first means no path can leave s4_pix unassigned, so no latch is inferred.
        s4_pix = '0;
        for (int c = 0; c < CHANNELS; c++)
            s4_pix[c*PIX_W +: PIX_W] = finish_sample(s3_part[c][0], s3_part[c][1],
                                                     s3_part[c][2], s3_part[c][3]);
    end

    // FIFO storage write. The S4 result enters at the tail.
    always_ff @(posedge i_clk) begin
        if (s3_valid) begin
            mem_pix[wr_ptr]  <= s4_pix;
            mem_user[wr_ptr] <= s3_user;
        end
    end

    // FIFO pointers and the registered head. The head holds its value while stalled or empty.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            o_valid <= 1'b0;
            o_pixel <= '0;
            o_user  <= '0;
        end else begin
            if (s3_valid) wr_ptr <= next_ptr(wr_ptr);
            if (load)     rd_ptr <= next_ptr(rd_ptr);
            mem_cnt <= mem_cnt + CNT_W'(s3_valid) - CNT_W'(load);
            if (load) begin
                o_valid <= 1'b1;
                o_pixel <= mem_pix[rd_ptr];
                o_user  <= mem_user[rd_ptr];
            end else if (pop) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bicubic_kernel_engine.sv
// tb_bicubic_kernel_engine
// Directed and random windows for bicubic_kernel_engine. Stimulus pushes the
// expected result for each accepted window into a queue. A negedge monitor
// pops the queue and compares on every output handshake. The monitor also
// checks o_ready against an independent credit count.
module tb_bicubic_kernel_engine;
    localparam int CH = 3, PW = 8, CW = 16, UW = 2, DEPTH = 8, TAPS = 16;
    localparam int PBUS = CH*TAPS*PW, WBUS = TAPS*CW, OBUS = CH*PW;

    typedef struct packed {
        logic [OBUS-1:0] pix;
        logic [UW-1:0]   user;
    } exp_t;

    logic            i_clk = 1'b0, i_reset = 1'b1, i_valid = 1'b0, i_ready = 1'b0;
    logic [PBUS-1:0] i_pixel = '0;
    logic [WBUS-1:0] i_weight = '0;
    logic [UW-1:0]   i_user = '0;
    logic            o_ready, o_valid;
    logic [OBUS-1:0] o_pixel;
    logic [UW-1:0]   o_user;

    int   checks = 0, errors = 0;
    int   model_occ = 0;
    int   ready_mode = 0;     // 0: i_ready low, 1: high, 2: random
    bit   mon_en = 1'b0;
    exp_t sb[$];

    bicubic_kernel_engine dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_pixel(i_pixel), .i_weight(i_weight), .i_user(i_user),
        .o_valid(o_valid), .i_ready(i_ready), .o_pixel(o_pixel), .o_user(o_user)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PBUS-1:0] pix_tap(input int k, input int v0, input int v1, input int v2);
        logic [PBUS-1:0] p = '0;
        p[(0*TAPS+k)*PW +: PW] = PW'(v0);
        p[(1*TAPS+k)*PW +: PW] = PW'(v1);
        p[(2*TAPS+k)*PW +: PW] = PW'(v2);
        return p;
    endfunction

    function automatic logic [PBUS-1:0] pix_all(input int v);
        logic [PBUS-1:0] p = '0;
        for (int i = 0; i < CH*TAPS; i++) p[i*PW +: PW] = PW'(v);
        return p;
    endfunction

    function automatic logic [WBUS-1:0] wt_tap(input int k, input int w);
        logic [WBUS-1:0] r = '0;
        r[k*CW +: CW] = CW'(w);
        return r;
    endfunction

    function automatic logic [WBUS-1:0] wt_all(input int w);
        logic [WBUS-1:0] r = '0;
        for (int k = 0; k < TAPS; k++) r[k*CW +: CW] = CW'(w);
        return r;
    endfunction

    function automatic logic [OBUS-1:0] opix(input int v0, input int v1, input int v2);
        return {PW'(v2), PW'(v1), PW'(v0)};
    endfunction

    function automatic logic [PBUS-1:0] rand_pix();
        logic [PBUS-1:0] p = '0;
        for (int i = 0; i < CH*TAPS; i++) p[i*PW +: PW] = PW'($urandom_range(0, 255));
        return p;
    endfunction

    function automatic logic [WBUS-1:0] rand_wt();
        logic [WBUS-1:0] r = '0;
        for (int k = 0; k < TAPS; k++) r[k*CW +: CW] = CW'(int'($urandom_range(0, 3300)) - 800);
        return r;
    endfunction

    // Integer reference: a signed dot product, then optional rounding, floor shift and clamp.
    function automatic logic [OBUS-1:0] model(input logic [PBUS-1:0] p, input logic [WBUS-1:0] w);
        logic [OBUS-1:0] r = '0;
        longint acc;
        for (int c = 0; c < CH; c++) begin
            acc = 0;
            for (int k = 0; k < TAPS; k++)
                acc += longint'(p[(c*TAPS+k)*PW +: PW]) * longint'($signed(w[k*CW +: CW]));
`ifdef BICUBIC_ROUND_EN
            acc += 8192;
`endif
            acc = acc >>> 14;
            if (acc < 0)        acc = 0;
            else if (acc > 255) acc = 255;
            r[c*PW +: PW] = PW'(acc);
        end
        return r;
    endfunction

    // Present one window until it is accepted. Call this task at posedge+1. It returns at posedge+1.
    task automatic send(input logic [PBUS-1:0] p, input logic [WBUS-1:0] w,
                        input logic [UW-1:0] u, input logic [OBUS-1:0] e);
        bit   done = 1'b0;
        logic rdy;
        i_valid = 1'b1; i_pixel = p; i_weight = w; i_user = u;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge i_clk); rdy = o_ready;
            @(posedge i_clk);
            if (rdy) begin
                sb.push_back({e, u});
                done = 1'b1;
            end
        end
        #1;
        i_valid = 1'b0; i_pixel = rand_pix(); i_weight = rand_wt(); i_user = UW'($urandom);
        if (!done) check("accept_timeout", 64'(done), 64'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge i_clk); n++;
        end
        #1;
        check("drain_remaining", 64'(sb.size()), 64'd0);
    endtask

    // Drive i_ready shortly after each edge, according to ready_mode.
    always @(posedge i_clk) begin
        #1;
        case (ready_mode)
            0:       i_ready = 1'b0;
            1:       i_ready = 1'b1;
            default: i_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compare o_ready with the credit model, and outputs with the scoreboard.
    always @(negedge i_clk) begin
        exp_t e;
        if (mon_en) begin
            check("o_ready_vs_credits", 64'(o_ready), 64'(model_occ < DEPTH));
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_o_valid", 64'(o_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("o_pixel", 64'(o_pixel), 64'(e.pix));
                    check("o_user", 64'(o_user), 64'(e.user));
                end
            end
            model_occ += int'(i_valid && o_ready) - int'(o_valid && i_ready);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc, stray;
        logic rdy;
        logic [PBUS-1:0] p;
        logic [WBUS-1:0] w;
        int   rnd;
`ifdef BICUBIC_ROUND_EN
        rnd = 2;
`else
        rnd = 1;
`endif
        // Reset state and release behaviour.
        #3 i_reset = 1'b0;
        #1;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_ready", 64'(o_ready), 64'd0);
        check("rst_o_pixel", 64'(o_pixel), 64'd0);
        check("rst_o_user", 64'(o_user), 64'd0);
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b1;
        @(negedge i_clk) check("ready_before_first_edge", 64'(o_ready), 64'd0);
        @(negedge i_clk) check("ready_after_first_edge", 64'(o_ready), 64'd1);
        mon_en = 1'b1; ready_mode = 1;
        @(posedge i_clk); #1;

        // Identity through tap 5. Check the edge-t+4 latency and the user echo.
        send(pix_tap(5, 200, 17, 255), wt_tap(5, 16384), 2'b10, opix(200, 17, 255));
        for (int i = 0; i < 4; i++) @(negedge i_clk) check("latency_not_yet", 64'(o_valid), 64'd0);
        @(negedge i_clk) check("latency_t_plus_4", 64'(o_valid), 64'd1);
        drain(20);

        // Clamp high and low.
        send(pix_all(255), wt_all(16384), 2'b01, opix(255, 255, 255));
        send(pix_all(100), wt_all(-4096), 2'b10, opix(0, 0, 0));
        // Rounding: 1.5 rounds up, -0.75 clamps to 0 in both builds.
        send(pix_tap(0, 3, 3, 3), wt_tap(0, 8192), 2'b11, opix(rnd, rnd, rnd));
        send(pix_tap(0, 5, 5, 5), wt_tap(0, -2458), 2'b00, opix(0, 0, 0));
        drain(40);

        // Backpressure: i_ready low for 20 cycles while i_valid stays high.
        @(negedge i_clk) ready_mode = 0;
        @(posedge i_clk); #1;
        acc = 0;
        i_valid = 1'b1; i_pixel = pix_tap(5, 0, 0, 0); i_weight = wt_tap(5, 16384); i_user = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge i_clk); rdy = o_ready;
            @(posedge i_clk);
            if (rdy) begin
                sb.push_back({opix(acc, acc, acc), UW'(acc)});
                acc++;
            end
            #1;
            i_pixel = pix_tap(5, acc, acc, acc); i_user = UW'(acc);
        end
        i_valid = 1'b0;
        check("bp_accept_count", 64'(acc), 64'(DEPTH));
        @(negedge i_clk);
        check("bp_ready_low_when_full", 64'(o_ready), 64'd0);
        check("bp_head_valid", 64'(o_valid), 64'd1);
        ready_mode = 1;
        @(negedge i_clk) check("bp_ready_low_until_pop", 64'(o_ready), 64'd0);
        @(negedge i_clk) check("bp_ready_after_first_pop", 64'(o_ready), 64'd1);
        drain(60);

        // Streaming: 100 random windows with random i_ready and occasional input gaps.
        @(negedge i_clk) ready_mode = 2;
        @(posedge i_clk); #1;
        for (int n = 0; n < 100; n++) begin
            p = rand_pix(); w = rand_wt();
            send(p, w, UW'($urandom), model(p, w));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge i_clk); #1;
            end
        end
        @(negedge i_clk) ready_mode = 1;
        drain(2000);

        // Assert reset in mid-stream with 6 windows accepted and none popped.
        @(negedge i_clk) ready_mode = 0;
        @(posedge i_clk); #1;
        for (int n = 0; n < 6; n++)
            send(pix_tap(5, n + 1, n + 2, n + 3), wt_tap(5, 16384), UW'(n), opix(n + 1, n + 2, n + 3));
        #2;
        mon_en = 1'b0;
        i_reset = 1'b0;
        #1;
        check("midrst_o_valid", 64'(o_valid), 64'd0);
        check("midrst_o_ready", 64'(o_ready), 64'd0);
        check("midrst_o_pixel", 64'(o_pixel), 64'd0);
        check("midrst_o_user", 64'(o_user), 64'd0);
        sb.delete();
        model_occ = 0;
        @(posedge i_clk); #2;
        check("midrst_ready_held", 64'(o_ready), 64'd0);
        i_reset = 1'b1;
        @(negedge i_clk) check("midrst_ready_pre_edge", 64'(o_ready), 64'd0);
        @(negedge i_clk) check("midrst_ready_post_edge", 64'(o_ready), 64'd1);
        mon_en = 1'b1; ready_mode = 1;
        stray = 0;
        repeat (20) @(negedge i_clk) if (o_valid) stray++;
        check("no_stale_output", 64'(stray), 64'd0);

        // The engine works again after reset.
        @(posedge i_clk); #1;
        send(pix_tap(5, 9, 128, 64), wt_tap(5, 16384), 2'b01, opix(9, 128, 64));
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
